pc_branch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_branch_unit_call_stack.sv | 30 +++
 rtl/pc_branch_unit.sv | 76 +++++++
 tb/tb_pc_branch_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-op, jump-condition, flag-index and PC-unit state definitions
package cpu_pkg;
  typedef enum logic [1:0] {OP_NEXT, OP_JUMP, OP_CALL, OP_RET} ctrl_op_e;
  typedef enum logic [2:0] {JMP, JEQ, JNE, JGT, JGE, JLT, JLE, JCR} jump_cond_e;
  typedef enum logic {RUN, FAULT} pcu_state_e;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic cond_true(input jump_cond_e c, input logic [3:0] f);
    logic z, n;
    z = f[FLAG_Z];
    n = f[FLAG_N];
    case (c)
      JMP: cond_true = 1'b1;
      JEQ: cond_true = z;
      JNE: cond_true = !z;
      JGT: cond_true = !z && !n;
      JGE: cond_true = !n;
      JLT: cond_true = n;
      JLE: cond_true = n || z;
      default: cond_true = f[FLAG_C];
    endcase
  endfunction
endpackage

// File: rtl/pc_branch_unit_call_stack.sv
// call_stack: parameterised LIFO of return addresses with saturating stack pointer
module call_stack #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  logic [PW-1:0] sp_q, sp_d;
  logic [W-1:0] mem_q [DEPTH];
  assign empty_o = sp_q == '0;
  assign full_o = sp_q == PW'(DEPTH);
  assign top_o = mem_q[AW'(sp_q - 1'b1)];
  always_comb sp_d = (push_i && !full_o) ? sp_q + 1'b1 : (pop_i && !empty_o) ? sp_q - 1'b1 : sp_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sp_q <= '0;
    else sp_q <= sp_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !full_o) mem_q[sp_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter with conditional jumps, call/return stack and sticky fault
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [1:0]      op_i,
  input  logic [2:0]      cond_i,
  input  logic [PC_W-1:0] target_i,
  input  logic [3:0]      flags_i,
  output logic [PC_W-1:0] pc_o,
  output logic            taken_o,
  output logic            stack_empty_o,
  output logic            stack_full_o,
  output logic            fault_o
);
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, top;
  logic taken_q, taken_d, push, pop;
  pcu_state_e state_q, state_d;
  assign pc_inc = pc_q + 1'b1;
  assign pc_o = pc_q;
  assign taken_o = taken_q;
  assign fault_o = state_q == FAULT;
  call_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_inc),
    .top_o  (top),
    .empty_o(stack_empty_o),
    .full_o (stack_full_o)
  );
  always_comb begin
    pc_d = pc_q;
    taken_d = taken_q;
    state_d = state_q;
    push = 1'b0;
    pop = 1'b0;
    if (en_i && state_q == RUN) begin
      pc_d = pc_inc;
      taken_d = 1'b0;
      case (ctrl_op_e'(op_i))
        OP_JUMP: if (cond_true(jump_cond_e'(cond_i), flags_i)) {pc_d, taken_d} = {target_i, 1'b1};
        OP_CALL: begin
          push = !stack_full_o;
          pc_d = stack_full_o ? pc_q : target_i;
          taken_d = !stack_full_o;
          state_d = stack_full_o ? FAULT : RUN;
        end
        OP_RET: begin
          pop = !stack_empty_o;
          pc_d = stack_empty_o ? pc_q : top;
          taken_d = !stack_empty_o;
          state_d = stack_empty_o ? FAULT : RUN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= '0;
      taken_q <= 1'b0;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      taken_q <= taken_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: vector table, directed corner sequences and random ops against a queue-based model
module tb_pc_branch_unit;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic en_i = 1'b0;
  logic [1:0] op_i = '0;
  logic [2:0] cond_i = '0;
  logic [7:0] target_i = '0;
  logic [3:0] flags_i = '0;
  logic [7:0] pc_o;
  logic taken_o, stack_empty_o, stack_full_o, fault_o;
  int checks = 0;
  int errors = 0;
  int m_pc, m_taken, m_fault;
  int m_stk[$];
  typedef struct {int op; int c; int t; int f; int pc; int tk;} vec_t;
  vec_t tbl[13];

  pc_branch_unit #(.PC_W(8), .STACK_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .op_i(op_i), .cond_i(cond_i),
    .target_i(target_i), .flags_i(flags_i), .pc_o(pc_o), .taken_o(taken_o),
    .stack_empty_o(stack_empty_o), .stack_full_o(stack_full_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cond_ok(input int c, input int f);
    bit z, n, cy;
    z = f[3];
    n = f[2];
    cy = f[1];
    case (c)
      0: return 1;
      1: return z;
      2: return !z;
      3: return !z && !n;
      4: return !n;
      5: return n;
      6: return n || z;
      default: return cy;
    endcase
  endfunction

  task automatic model(input int rst, input int en, input int op, input int c, input int t, input int f);
    if (!rst) begin
      m_pc = 0; m_taken = 0; m_fault = 0; m_stk.delete();
    end else if (en && !m_fault) begin
      case (op)
        0: begin m_pc = (m_pc + 1) % 256; m_taken = 0; end
        1: if (cond_ok(c, f) != 0) begin m_pc = t; m_taken = 1; end
           else begin m_pc = (m_pc + 1) % 256; m_taken = 0; end
        2: if (m_stk.size() == 8) begin m_fault = 1; m_taken = 0; end
           else begin m_stk.push_back((m_pc + 1) % 256); m_pc = t; m_taken = 1; end
        default: if (m_stk.size() == 0) begin m_fault = 1; m_taken = 0; end
           else begin m_pc = m_stk.pop_back(); m_taken = 1; end
      endcase
    end
  endtask

  task automatic step(input int rst, input int en, input int op, input int c, input int t, input int f);
    rst_ni = rst[0]; en_i = en[0]; op_i = 2'(op); cond_i = 3'(c); target_i = 8'(t); flags_i = 4'(f);
    @(posedge clk_i);
    #1;
    model(rst, en, op, c, t, f);
    chk("pc", int'(pc_o), m_pc);
    chk("taken", int'(taken_o), m_taken);
    chk("empty", int'(stack_empty_o), int'(m_stk.size() == 0));
    chk("full", int'(stack_full_o), int'(m_stk.size() == 8));
    chk("fault", int'(fault_o), m_fault);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{0, 0, 0, 0, i + 1, 0};
    tbl[5]  = '{1, 1, 'h40, 'b1000, 'h40, 1};
    tbl[6]  = '{1, 1, 'h40, 'b0000, 'h41, 0};
    tbl[7]  = '{1, 0, 'h10, 0, 'h10, 1};
    tbl[8]  = '{2, 0, 'h80, 0, 'h80, 1};
    tbl[9]  = '{0, 0, 0, 0, 'h81, 0};
    tbl[10] = '{0, 0, 0, 0, 'h82, 0};
    tbl[11] = '{3, 0, 0, 0, 'h11, 1};
    tbl[12] = '{1, 7, 'hFF, 'b0010, 'hFF, 1};
    step(0, 0, 0, 0, 0, 0);
    chk("reset_pc", int'(pc_o), 0);
    chk("reset_empty", int'(stack_empty_o), 1);
    for (int i = 0; i < 13; i++) begin
      step(1, 1, tbl[i].op, tbl[i].c, tbl[i].t, tbl[i].f);
      chk($sformatf("tbl%0d_pc", i), int'(pc_o), tbl[i].pc);
      chk($sformatf("tbl%0d_taken", i), int'(taken_o), tbl[i].tk);
    end
    chk("ret_empty", int'(stack_empty_o), 1);
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 16; f++) step(1, 1, 1, c, int'($urandom_range(255)), f);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 2, 0, 'h20 + i, 0);
    chk("nest_full", int'(stack_full_o), 1);
    step(1, 1, 2, 0, 'h99, 0);
    chk("ovf_fault", int'(fault_o), 1);
    chk("ovf_pc", int'(pc_o), 'h27);
    step(1, 1, 1, 0, 'h55, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("fault_frozen", int'(pc_o), 'h27);
    step(0, 1, 0, 0, 0, 0);
    chk("fault_reset", int'(fault_o), 0);
    step(1, 1, 1, 0, 'h22, 0);
    step(1, 1, 3, 0, 0, 0);
    chk("unf_fault", int'(fault_o), 1);
    chk("unf_pc", int'(pc_o), 'h22);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 'hFF, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("wrap_pc", int'(pc_o), 0);
    step(1, 1, 1, 0, 'hFF, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2, 0, 'h30, 0);
    chk("en0_pc", int'(pc_o), 'hFF);
    step(1, 1, 2, 0, 'h30, 0);
    step(1, 1, 3, 0, 0, 0);
    chk("wrap_ret", int'(pc_o), 0);
    step(1, 1, 1, 0, 'hFF, 0);
    step(0, 1, 2, 0, 'h30, 0);
    chk("rst_call_pc", int'(pc_o), 0);
    chk("rst_call_empty", int'(stack_empty_o), 1);
    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(199) != 0), int'($urandom_range(9) != 0), int'($urandom_range(3)),
           int'($urandom_range(7)), int'($urandom_range(255)), int'($urandom_range(15)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
